// File: rtl/w2rsync_multi.sv
// Read-side write-pointer synchroniser: brings the Gray write pointer into rclk, decodes it and
// derives read-side occupancy, empty/almost-empty flags and a sticky illegal-Gray-jump flag.
module w2rsync_multi #(
  parameter int ADDRSIZE      = 9,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              rclk,
  input  logic              r_rst,
  input  logic [ADDRSIZE:0] wptr,
  input  logic [ADDRSIZE:0] rptr_bin,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] wptr_sync,
  output logic [ADDRSIZE:0] wptr_sync_bin,
  output logic [ADDRSIZE:0] rcount,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic              sync_valid,
  output logic              gray_err
);

  typedef logic [ADDRSIZE:0] ptr_t;

  localparam ptr_t       THRESH    = ptr_t'(AEMPTY_THRESH);
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("w2rsync_multi: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic multi_bit_change(input ptr_t a, input ptr_t b);
    return $countones(a ^ b) > 1;
  endfunction

  ptr_t       sync_chain [SYNC_STAGES];
  ptr_t       wbin_nxt;
  ptr_t       cnt_nxt;
  logic [2:0] warm_cnt;
  logic [2:0] warm_nxt;
  logic       jump_bad;

  // Decode looks one stage early so the registered outputs line up with wptr_sync
  always_comb begin
    wbin_nxt = gray2bin(sync_chain[SYNC_STAGES-2]);
    cnt_nxt  = wbin_nxt - rptr_bin;
    warm_nxt = (warm_cnt == WARM_DONE) ? warm_cnt : warm_cnt + 3'd1;
    jump_bad = multi_bit_change(sync_chain[SYNC_STAGES-2], sync_chain[SYNC_STAGES-1]);
  end

  assign wptr_sync = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
      wptr_sync_bin <= '0;
      rcount        <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      warm_cnt      <= 3'd0;
      sync_valid    <= 1'b0;
      gray_err      <= 1'b0;
    end else begin
      sync_chain[0] <= wptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
      wptr_sync_bin <= wbin_nxt;
      rcount        <= cnt_nxt;
      rempty        <= (cnt_nxt == '0);
      ralmost_empty <= (cnt_nxt <= THRESH);
      warm_cnt      <= warm_nxt;
      sync_valid    <= (warm_nxt == WARM_DONE);
      // A fault arriving in the same cycle as a clear keeps the flag set
      if (sync_valid && jump_bad) gray_err <= 1'b1;
      else if (err_clr)           gray_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w2rsync_multi.sv
// Directed bench for w2rsync_multi: three instances (SYNC_STAGES 2, 3, 4) share the same stimulus
// and are compared against hand-computed expectations.
module tb_w2rsync_multi;

  localparam int AW = 9;
  typedef logic [AW:0] ptr_t;

  logic rclk = 1'b0;
  logic r_rst, err_clr;
  ptr_t wptr, rptr_bin;

  ptr_t ws2, ws3, ws4, wb2, wb3, wb4, rc2, rc3, rc4;
  logic re2, re3, re4, ra2, ra3, ra4, sv2, sv3, sv4, ge2, ge3, ge4;

  ptr_t ws [3];
  ptr_t wb [3];
  ptr_t rc [3];
  logic re [3];
  logic ra [3];
  logic sv [3];
  logic ge [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 rclk = ~rclk;

  always_comb begin
    ws[0] = ws2; ws[1] = ws3; ws[2] = ws4;
    wb[0] = wb2; wb[1] = wb3; wb[2] = wb4;
    rc[0] = rc2; rc[1] = rc3; rc[2] = rc4;
    re[0] = re2; re[1] = re3; re[2] = re4;
    ra[0] = ra2; ra[1] = ra3; ra[2] = ra4;
    sv[0] = sv2; sv[1] = sv3; sv[2] = sv4;
    ge[0] = ge2; ge[1] = ge3; ge[2] = ge4;
  end

  w2rsync_multi #(.ADDRSIZE(AW), .SYNC_STAGES(2), .AEMPTY_THRESH(4)) dut2 (
    .rclk(rclk), .r_rst(r_rst), .wptr(wptr), .rptr_bin(rptr_bin), .err_clr(err_clr),
    .wptr_sync(ws2), .wptr_sync_bin(wb2), .rcount(rc2), .rempty(re2),
    .ralmost_empty(ra2), .sync_valid(sv2), .gray_err(ge2));

  w2rsync_multi #(.ADDRSIZE(AW), .SYNC_STAGES(3), .AEMPTY_THRESH(4)) dut3 (
    .rclk(rclk), .r_rst(r_rst), .wptr(wptr), .rptr_bin(rptr_bin), .err_clr(err_clr),
    .wptr_sync(ws3), .wptr_sync_bin(wb3), .rcount(rc3), .rempty(re3),
    .ralmost_empty(ra3), .sync_valid(sv3), .gray_err(ge3));

  w2rsync_multi #(.ADDRSIZE(AW), .SYNC_STAGES(4), .AEMPTY_THRESH(4)) dut4 (
    .rclk(rclk), .r_rst(r_rst), .wptr(wptr), .rptr_bin(rptr_bin), .err_clr(err_clr),
    .wptr_sync(ws4), .wptr_sync_bin(wb4), .rcount(rc4), .rempty(re4),
    .ralmost_empty(ra4), .sync_valid(sv4), .gray_err(ge4));

  function automatic ptr_t gray(input int b);
    ptr_t v;
    v = ptr_t'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_wsync_n%0d", tag, i + 2), int'(ws[i]), 0);
      check($sformatf("%s_wbin_n%0d", tag, i + 2), int'(wb[i]), 0);
      check($sformatf("%s_rcount_n%0d", tag, i + 2), int'(rc[i]), 0);
      check($sformatf("%s_rempty_n%0d", tag, i + 2), int'(re[i]), 1);
      check($sformatf("%s_raempty_n%0d", tag, i + 2), int'(ra[i]), 1);
      check($sformatf("%s_svalid_n%0d", tag, i + 2), int'(sv[i]), 0);
      check($sformatf("%s_gerr_n%0d", tag, i + 2), int'(ge[i]), 0);
    end
  endtask

  initial begin
    r_rst = 1'b1; wptr = '0; rptr_bin = '0; err_clr = 1'b0;
    step(1);
    check_reset("reset");
    r_rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      for (int i = 0; i < 3; i++)
        check($sformatf("warm_k%0d_n%0d", k, i + 2), int'(sv[i]), int'(k >= i + 2));
    end

    // Latency: 0 -> gray(5) is a 3-bit jump, so gray_err also rises with wptr_sync
    wptr = gray(5);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("lat_wsync_k%0d_n%0d", k, i + 2), int'(ws[i]), (k >= i + 2) ? int'(gray(5)) : 0);
        check($sformatf("lat_wbin_k%0d_n%0d", k, i + 2), int'(wb[i]), (k >= i + 2) ? 5 : 0);
        check($sformatf("lat_rcount_k%0d_n%0d", k, i + 2), int'(rc[i]), (k >= i + 2) ? 5 : 0);
        check($sformatf("lat_rempty_k%0d_n%0d", k, i + 2), int'(re[i]), int'(k < i + 2));
        check($sformatf("lat_raempty_k%0d_n%0d", k, i + 2), int'(ra[i]), int'(k < i + 2));
        check($sformatf("lat_gerr_k%0d_n%0d", k, i + 2), int'(ge[i]), int'(k >= i + 2));
      end
    end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    for (int i = 0; i < 3; i++) check($sformatf("clr1_gerr_n%0d", i + 2), int'(ge[i]), 0);

    // Empty / almost-empty sweep
    for (int r = 0; r <= 5; r++) begin
      rptr_bin = ptr_t'(r);
      step(1);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("sweep_rcount_r%0d_n%0d", r, i + 2), int'(rc[i]), 5 - r);
        check($sformatf("sweep_raempty_r%0d_n%0d", r, i + 2), int'(ra[i]), int'(r >= 1));
        check($sformatf("sweep_rempty_r%0d_n%0d", r, i + 2), int'(re[i]), int'(r == 5));
      end
    end

    // Wrap: 1 - 1020 mod 1024 = 5; gray(5) -> gray(1) is a 2-bit jump
    wptr = gray(1); rptr_bin = ptr_t'(1020);
    step(4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_rcount_n%0d", i + 2), int'(rc[i]), 5);
      check($sformatf("wrap_rempty_n%0d", i + 2), int'(re[i]), 0);
      check($sformatf("wrap_wbin_n%0d", i + 2), int'(wb[i]), 1);
      check($sformatf("wrap_gerr_n%0d", i + 2), int'(ge[i]), 1);
    end
    rptr_bin = ptr_t'(1);
    step(1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("eq_rcount_n%0d", i + 2), int'(rc[i]), 0);
      check($sformatf("eq_rempty_n%0d", i + 2), int'(re[i]), 1);
      check($sformatf("eq_raempty_n%0d", i + 2), int'(ra[i]), 1);
    end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    for (int i = 0; i < 3; i++) check($sformatf("clr2_gerr_n%0d", i + 2), int'(ge[i]), 0);

    // Gray fault: legal single-bit steps, then gray(3)=0010 -> 0111 (2 bits)
    wptr = gray(2); step(1);
    wptr = gray(3); step(4);
    for (int i = 0; i < 3; i++) check($sformatf("legal_gerr_n%0d", i + 2), int'(ge[i]), 0);
    wptr = gray(4) ^ ptr_t'(1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      for (int i = 0; i < 3; i++)
        check($sformatf("fault_gerr_k%0d_n%0d", k, i + 2), int'(ge[i]), int'(k >= i + 2));
    end
    for (int i = 0; i < 3; i++) check($sformatf("fault_rcount_n%0d", i + 2), int'(rc[i]), 4);
    step(2);
    for (int i = 0; i < 3; i++) check($sformatf("hold_gerr_n%0d", i + 2), int'(ge[i]), 1);
    // Clear held high while a new 2-bit jump (0111 -> 0010) arrives: set wins only on its edge
    wptr = gray(3); err_clr = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      for (int i = 0; i < 3; i++)
        check($sformatf("setclr_gerr_k%0d_n%0d", k, i + 2), int'(ge[i]), int'(k == i + 2));
    end
    err_clr = 1'b0;

    // Mid-operation reset with rcount = 3 - 1020 mod 1024 = 7
    rptr_bin = ptr_t'(1020);
    step(1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pre_rcount_n%0d", i + 2), int'(rc[i]), 7);
      check($sformatf("pre_raempty_n%0d", i + 2), int'(ra[i]), 0);
    end
    r_rst = 1'b1; step(1); r_rst = 1'b0;
    check_reset("midrst");
    for (int k = 1; k <= 4; k++) begin
      step(1);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("refill_svalid_k%0d_n%0d", k, i + 2), int'(sv[i]), int'(k >= i + 2));
        check($sformatf("refill_rcount_k%0d_n%0d", k, i + 2), int'(rc[i]), (k >= i + 2) ? 7 : 4);
        check($sformatf("refill_gerr_k%0d_n%0d", k, i + 2), int'(ge[i]), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
